vga_timing_decoder: RTL

Receive-side counterpart of the `vga` timing generator. Samples the sync, blank and RGB lines the generator drives toward the DAC and reconstructs pixel coordinates, measured line/frame geometry and lock status. Checks timing conformance against 640x480@60 and captures the pixel at a programmable probe coordinate. Sits beside `vga` in `top`, driven from the same `VGA_*` nets; it feeds debug/HEX display logic and the self-checking bench.

---
 rtl/vga_timing_decoder_pkg.sv | 29 ++
 rtl/vga_timing_decoder_sync_edge_det.sv | 23 ++
 rtl/vga_timing_decoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_decoder_pkg.sv
// Shared 640x480@60 timing constants and lock FSM encodings
// for the VGA timing decoder and its companion generator.
package vga_timing_decoder_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL_DEF  = H_SYNC + H_BP + H_ACTIVE_DEF + H_FP;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL_DEF  = V_SYNC + V_BP + V_ACTIVE_DEF + V_FP;

    localparam int CW = 10;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_timing_decoder_sync_edge_det.sv
// Registered falling-edge detector for an active-low sync line.
// The history register idles high so a quiet line never reports an edge.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_sync,
    output logic o_fall
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b1;
        end else if (i_en) begin
            r_q <= i_sync;
        end
    end

    assign o_fall = i_en & r_q & ~i_sync;

endmodule

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: rebuilds coordinates, measures
// line/frame geometry, tracks lock and captures a probe pixel.
module vga_timing_decoder
    import vga_timing_decoder_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank_n,
    input  logic [23:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    input  logic        clear_err,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        h_err,
    output logic        v_err,
    output logic        a_err,
    output logic [23:0] probe_rgb,
    output logic        probe_valid,
    output logic [7:0]  frame_cnt
);

    localparam logic [9:0] LP_HT   = 10'(H_TOTAL);
    localparam logic [9:0] LP_VT   = 10'(V_TOTAL);
    localparam logic [9:0] LP_HA   = 10'(H_ACTIVE);
    localparam logic [9:0] LP_VA   = 10'(V_ACTIVE);
    localparam logic [7:0] LP_LOCK = 8'(LOCK_FRAMES);

    logic w_hs_fall;
    logic w_vs_fall;

    sync_edge_det u_hs_det (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_en    (pix_en),
        .i_sync  (hs),
        .o_fall  (w_hs_fall)
    );

    sync_edge_det u_vs_det (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_en    (pix_en),
        .i_sync  (vs),
        .o_fall  (w_vs_fall)
    );

    lock_state_e r_state;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_acnt;
    logic [9:0]  r_vcnt;
    logic [9:0]  r_vact;
    logic [7:0]  r_good;
    logic        r_line_bad;
    logic        r_probe_done;

    logic [9:0]  w_line_len;
    logic [9:0]  w_acnt_cur;
    logic [9:0]  w_x_pix;
    logic [9:0]  w_y_ln;
    logic [9:0]  w_y_pix;
    logic [9:0]  w_vcnt_ln;
    logic [9:0]  w_vact_ln;
    logic [7:0]  w_good_inc;
    logic        w_line_act;
    logic        w_line_h_bad;
    logic        w_line_a_bad;
    logic        w_fr_v_bad;
    logic        w_fr_act_bad;
    logic        w_fr_bad;
    logic        w_is_locked;
    logic        w_set_h;
    logic        w_set_v;
    logic        w_set_a;
    logic        w_probe_hit;

    // Line accounting for the line that ends at this HS fall.
    assign w_line_len   = sat_inc(r_hcnt);
    assign w_line_act   = (r_acnt != '0);
    assign w_line_h_bad = (w_line_len != LP_HT);
    assign w_line_a_bad = w_line_act && (r_acnt != LP_HA);

    assign w_acnt_cur = w_hs_fall ? '0 : r_acnt;
    assign w_x_pix    = (w_acnt_cur == '0) ? '0 : sat_inc(x);
    assign w_y_ln     = (w_hs_fall && w_line_act) ? sat_inc(y) : y;
    assign w_y_pix    = w_vs_fall ? '0 : w_y_ln;

    // Frame totals include a line closed by a coincident HS fall.
    assign w_vcnt_ln    = w_hs_fall ? sat_inc(r_vcnt) : r_vcnt;
    assign w_vact_ln    = (w_hs_fall && w_line_act) ? sat_inc(r_vact) : r_vact;
    assign w_fr_v_bad   = (w_vcnt_ln != LP_VT);
    assign w_fr_act_bad = (w_vact_ln != LP_VA);
    assign w_fr_bad     = r_line_bad | w_fr_v_bad | w_fr_act_bad |
                          (w_hs_fall & (w_line_h_bad | w_line_a_bad));

    assign w_is_locked = (r_state == ST_LOCKED);
    assign w_set_h     = w_is_locked & w_hs_fall & w_line_h_bad;
    assign w_set_v     = w_is_locked & w_vs_fall & w_fr_v_bad;
    assign w_set_a     = w_is_locked &
                         ((w_hs_fall & w_line_a_bad) | (w_vs_fall & w_fr_act_bad));
    assign w_good_inc  = r_good + 8'd1;

    assign w_probe_hit = pix_en & blank_n & (w_vs_fall | ~r_probe_done) &
                         (w_x_pix == probe_x) & (w_y_pix == probe_y);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_hcnt       <= '0;
            r_acnt       <= '0;
            r_vcnt       <= '0;
            r_vact       <= '0;
            r_line_bad   <= 1'b0;
            r_probe_done <= 1'b0;
            x            <= '0;
            y            <= '0;
            de           <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            line_len     <= '0;
            frame_lines  <= '0;
            probe_rgb    <= '0;
            probe_valid  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            line_start  <= w_hs_fall;
            frame_start <= w_vs_fall;
            probe_valid <= w_probe_hit;
            if (pix_en) begin
                de <= blank_n;
                if (w_hs_fall) begin
                    r_hcnt   <= '0;
                    r_acnt   <= {9'd0, blank_n};
                    line_len <= w_line_len;
                end else begin
                    r_hcnt <= sat_inc(r_hcnt);
                    if (blank_n) begin
                        r_acnt <= sat_inc(r_acnt);
                    end
                end
                if (blank_n || w_hs_fall) begin
                    x <= w_x_pix;
                end
                y <= w_y_pix;
                if (w_vs_fall) begin
                    r_vcnt      <= '0;
                    r_vact      <= '0;
                    r_line_bad  <= 1'b0;
                    frame_lines <= w_vcnt_ln;
                    frame_cnt   <= frame_cnt + 8'd1;
                end else begin
                    r_vcnt     <= w_vcnt_ln;
                    r_vact     <= w_vact_ln;
                    r_line_bad <= r_line_bad |
                                  (w_hs_fall & (w_line_h_bad | w_line_a_bad));
                end
                if (w_probe_hit) begin
                    probe_rgb    <= rgb;
                    r_probe_done <= 1'b1;
                end else if (w_vs_fall) begin
                    r_probe_done <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SEARCH;
            r_good  <= '0;
            locked  <= 1'b0;
            h_err   <= 1'b0;
            v_err   <= 1'b0;
            a_err   <= 1'b0;
        end else if (pix_en) begin
            if (w_set_h)        h_err <= 1'b1;
            else if (clear_err) h_err <= 1'b0;
            if (w_set_v)        v_err <= 1'b1;
            else if (clear_err) v_err <= 1'b0;
            if (w_set_a)        a_err <= 1'b1;
            else if (clear_err) a_err <= 1'b0;
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_vs_fall) begin
                        r_state <= ST_MEASURE;
                        r_good  <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_vs_fall) begin
                        if (w_fr_bad) begin
                            r_good <= '0;
                        end else if (w_good_inc >= LP_LOCK) begin
                            r_good  <= '0;
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            r_good <= w_good_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_set_h || w_set_v || w_set_a) begin
                        r_state <= ST_SEARCH;
                        locked  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
